// File: rtl/rect_plotter.sv
// Rectangle fill engine for the vga_adapter: queues up to two requests and emits one pixel per cycle.
// Define RECT_PLOTTER_CLIP_EN to suppress vga_plot for pixels outside SCREEN_W x SCREEN_H.
//   state | meaning
//   IDLE  | nothing to draw, waiting for a queued request
//   LOAD  | pop head request, clear col/row counters
//   DRAW  | one pixel per cycle, column fastest
//   DONE  | one-cycle done pulse, then next request or idle
module rect_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [4:0] req_w,
  input  logic [4:0] req_h,
  input  logic [2:0] req_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [4:0] w;
    logic [4:0] h;
    logic [2:0] c;
  } rect_t;

  localparam logic [8:0] SCREEN_W9 = 9'(SCREEN_W);
  localparam logic [7:0] SCREEN_H8 = 8'(SCREEN_H);

  state_t     state_q, state_d;
  rect_t      fifo_q [2];
  rect_t      fifo_d [2];
  logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  rect_t      cur_q, cur_d, head;
  logic [4:0] col_q, col_d, row_q, row_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d, done_q, done_d;
  logic       push, pop, in_screen;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  function automatic logic [4:0] sat16(input logic [4:0] v);
    return (v > 5'd16) ? 5'd16 : v;
  endfunction

  assign req_ready  = (count_q < 2'd2);
  assign busy       = (state_q != IDLE) || (count_q != 2'd0);
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign done       = done_q;

  always_comb begin
    push     = req_valid && req_ready;
    pop      = (state_q == LOAD);
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{x: req_x, y: req_y, w: sat16(req_w), h: sat16(req_h), c: req_colour};
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    head    = fifo_q[rd_ptr_q];
    state_d = state_q;
    cur_d   = cur_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      IDLE: if (count_q != 2'd0) state_d = LOAD;
      LOAD: begin
        cur_d   = head;
        col_d   = 5'd0;
        row_d   = 5'd0;
        state_d = (head.w == 5'd0 || head.h == 5'd0) ? DONE : DRAW;
      end
      DRAW: begin
        if (col_q == cur_q.w - 5'd1) begin
          col_d = 5'd0;
          if (row_q == cur_q.h - 5'd1) state_d = DONE;
          else row_d = row_q + 5'd1;
        end else begin
          col_d = col_q + 5'd1;
        end
      end
      default: state_d = (count_q != 2'd0) ? LOAD : IDLE;
    endcase

    // Outputs are computed from next-state values so they line up with state_q.
    sum_x        = {1'b0, cur_d.x} + {4'b0, col_d};
    sum_y        = {1'b0, cur_d.y} + {3'b0, row_d};
    in_screen    = (sum_x < SCREEN_W9) && (sum_y < SCREEN_H8);
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    if (state_d == DRAW) begin
      vga_x_d      = sum_x[7:0];
      vga_y_d      = sum_y[6:0];
      vga_colour_d = cur_d.c;
`ifdef RECT_PLOTTER_CLIP_EN
      vga_plot_d   = in_screen;
`else
      vga_plot_d   = 1'b1;
`endif
    end
    done_d = (state_d == DONE);
  end

`ifndef RECT_PLOTTER_CLIP_EN
  logic unused_in_screen;
  assign unused_in_screen = in_screen;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      cur_q        <= '0;
      col_q        <= 5'd0;
      row_q        <= 5'd0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      vga_plot_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cur_q        <= cur_d;
      col_q        <= col_d;
      row_q        <= row_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: logs every plotted pixel and done pulse with its cycle number.
module tb_rect_plotter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_x = '0;
  logic [6:0] req_y = '0;
  logic [4:0] req_w = '0;
  logic [4:0] req_h = '0;
  logic [2:0] req_colour = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

  rect_plotter dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_colour(req_colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int pc[$];
  int px[$];
  int py[$];
  int pk[$];
  int dc[$];
  bit saw_not_ready;

  always @(negedge clock) begin
    if (vga_plot === 1'b1) begin
      pc.push_back(cyc);
      px.push_back(int'(vga_x));
      py.push_back(int'(vga_y));
      pk.push_back(int'(vga_colour));
    end
    if (done === 1'b1) dc.push_back(cyc);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic clear_log();
    pc.delete(); px.delete(); py.delete(); pk.delete(); dc.delete();
  endtask

  task automatic push(input logic [7:0] x, input logic [6:0] y, input logic [4:0] w,
                      input logic [4:0] h, input logic [2:0] c, output int a);
    int guard;
    guard = 0;
    req_x = x; req_y = y; req_w = w; req_h = h; req_colour = c;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && guard < 50) begin
      saw_not_ready = 1'b1;
      @(negedge clock);
      #1;
      guard++;
    end
    if (guard >= 50) begin
      total++; bad++;
      $display("FAIL push_timeout: req_ready=%b required 1", req_ready);
      req_valid = 1'b0;
      a = -1000;
      return;
    end
    @(posedge clock);
    #1;
    a = cyc;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_x = 8'd5; req_y = 7'd5; req_w = 5'd2; req_h = 5'd2; req_colour = 3'd1;
    req_valid = 1'b1;
    wait_cyc(3);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock); #1;
    total++; if (vga_plot !== 1'b0) begin bad++; $display("FAIL rst_plot: got %b want 0", vga_plot); end
    total++; if (vga_x !== 8'd0) begin bad++; $display("FAIL rst_x: got %0d want 0", vga_x); end
    total++; if (vga_y !== 7'd0) begin bad++; $display("FAIL rst_y: got %0d want 0", vga_y); end
    total++; if (vga_colour !== 3'd0) begin bad++; $display("FAIL rst_colour: got %0d want 0", vga_colour); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    wait_cyc(8);
    total++; if (pc.size() !== 0) begin bad++; $display("FAIL rst_discard_plots: got %0d want 0", pc.size()); end
    total++; if (dc.size() !== 0) begin bad++; $display("FAIL rst_discard_done: got %0d want 0", dc.size()); end
  endtask

  task automatic test_basic();
    int a;
    int ex[4] = '{20, 21, 20, 21};
    int ey[4] = '{60, 60, 61, 61};
    clear_log();
    push(8'd20, 7'd60, 5'd2, 5'd2, 3'b100, a);
    wait_cyc(12);
    total++; if (pc.size() !== 4) begin bad++; $display("FAIL basic_count: got %0d want 4", pc.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < pc.size()) begin
        total++;
        if (pc[i] !== a + 2 + i || px[i] !== ex[i] || py[i] !== ey[i] || pk[i] !== 4) begin
          bad++;
          $display("FAIL basic_px%0d: got cyc=%0d (%0d,%0d) c=%0d want cyc=%0d (%0d,%0d) c=4",
                   i, pc[i], px[i], py[i], pk[i], a + 2 + i, ex[i], ey[i]);
        end
      end
    end
    total++;
    if (dc.size() !== 1 || dc[0] !== a + 6) begin
      bad++; $display("FAIL basic_done: got n=%0d cyc=%0d want n=1 cyc=%0d", dc.size(), dc[0], a + 6);
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, a3;
    clear_log();
    saw_not_ready = 1'b0;
    push(8'd10, 7'd5, 5'd4, 5'd1, 3'd1, a1);
    push(8'd30, 7'd5, 5'd4, 5'd1, 3'd2, a2);
    push(8'd50, 7'd5, 5'd4, 5'd1, 3'd3, a3);
    wait_cyc(25);
    total++; if (saw_not_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_low: got %b want 1", saw_not_ready); end
    total++; if (a3 !== a1 + 3) begin bad++; $display("FAIL b2b_accept3: got %0d want %0d", a3, a1 + 3); end
    total++; if (pc.size() !== 12) begin bad++; $display("FAIL b2b_count: got %0d want 12", pc.size()); end
    for (int k = 0; k < 12; k++) begin
      int r, i;
      r = k / 4; i = k % 4;
      if (k < pc.size()) begin
        total++;
        if (pc[k] !== a1 + 2 + 6 * r + i || px[k] !== 10 + 20 * r + i || py[k] !== 5 || pk[k] !== r + 1) begin
          bad++;
          $display("FAIL b2b_px%0d: got cyc=%0d (%0d,%0d) c=%0d want cyc=%0d (%0d,5) c=%0d",
                   k, pc[k], px[k], py[k], pk[k], a1 + 2 + 6 * r + i, 10 + 20 * r + i, r + 1);
        end
      end
    end
    total++; if (dc.size() !== 3) begin bad++; $display("FAIL b2b_done_count: got %0d want 3", dc.size()); end
    for (int r = 0; r < 3; r++) begin
      if (r < dc.size()) begin
        total++;
        if (dc[r] !== a1 + 6 + 6 * r) begin
          bad++; $display("FAIL b2b_done%0d: got cyc=%0d want %0d", r, dc[r], a1 + 6 + 6 * r);
        end
      end
    end
  endtask

  task automatic test_zero_area();
    int a;
    clear_log();
    push(8'd70, 7'd10, 5'd0, 5'd5, 3'd5, a);
    wait_cyc(8);
    total++; if (pc.size() !== 0) begin bad++; $display("FAIL zero_plots: got %0d want 0", pc.size()); end
    total++;
    if (dc.size() !== 1 || dc[0] !== a + 2) begin
      bad++; $display("FAIL zero_done: got n=%0d cyc=%0d want n=1 cyc=%0d", dc.size(), dc[0], a + 2);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy); end
  endtask

  task automatic test_clip();
    int a;
    int ec[$];
    int ex[$];
    int ey[$];
    clear_log();
    push(8'd158, 7'd118, 5'd4, 5'd4, 3'd7, a);
    wait_cyc(24);
    for (int k = 0; k < 16; k++) begin
      int sx, sy;
      sx = 158 + k % 4; sy = 118 + k / 4;
`ifdef RECT_PLOTTER_CLIP_EN
      if (sx < 160 && sy < 120) begin
        ec.push_back(a + 2 + k); ex.push_back(sx); ey.push_back(sy);
      end
`else
      ec.push_back(a + 2 + k); ex.push_back(sx % 256); ey.push_back(sy % 128);
`endif
    end
    total++; if (pc.size() !== ec.size()) begin bad++; $display("FAIL clip_count: got %0d want %0d", pc.size(), ec.size()); end
    for (int k = 0; k < ec.size(); k++) begin
      if (k < pc.size()) begin
        total++;
        if (pc[k] !== ec[k] || px[k] !== ex[k] || py[k] !== ey[k] || pk[k] !== 7) begin
          bad++;
          $display("FAIL clip_px%0d: got cyc=%0d (%0d,%0d) c=%0d want cyc=%0d (%0d,%0d) c=7",
                   k, pc[k], px[k], py[k], pk[k], ec[k], ex[k], ey[k]);
        end
      end
    end
    total++;
    if (dc.size() !== 1 || dc[0] !== a + 18) begin
      bad++; $display("FAIL clip_done: got n=%0d cyc=%0d want n=1 cyc=%0d", dc.size(), dc[0], a + 18);
    end
  endtask

  task automatic test_saturate();
    int a;
    clear_log();
    push(8'd0, 7'd0, 5'd31, 5'd1, 3'd2, a);
    wait_cyc(24);
    total++; if (pc.size() !== 16) begin bad++; $display("FAIL sat_count: got %0d want 16", pc.size()); end
    if (pc.size() == 16) begin
      total++;
      if (px[15] !== 15 || pc[15] !== a + 17) begin
        bad++; $display("FAIL sat_last: got x=%0d cyc=%0d want x=15 cyc=%0d", px[15], pc[15], a + 17);
      end
    end
    total++;
    if (dc.size() !== 1 || dc[0] !== a + 18) begin
      bad++; $display("FAIL sat_done: got n=%0d cyc=%0d want n=1 cyc=%0d", dc.size(), dc[0], a + 18);
    end
  endtask

  task automatic test_reset_mid();
    int a, b, guard;
    clear_log();
    push(8'd40, 7'd40, 5'd8, 5'd8, 3'd6, a);
    push(8'd90, 7'd90, 5'd1, 5'd1, 3'd1, b);
    guard = 0;
    while (pc.size() < 3 && guard < 40) begin
      @(negedge clock); #1;
      guard++;
    end
    total++; if (pc.size() !== 3) begin bad++; $display("FAIL mid_reach3: got %0d want 3", pc.size()); end
    reset = 1'b1;
    @(negedge clock); #1;
    total++; if (vga_plot !== 1'b0) begin bad++; $display("FAIL mid_plot: got %b want 0", vga_plot); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_done_now: got %b want 0", done); end
    reset = 1'b0;
    wait_cyc(30);
    total++; if (pc.size() !== 3) begin bad++; $display("FAIL mid_lost: got %0d plots want 3", pc.size()); end
    total++; if (dc.size() !== 0) begin bad++; $display("FAIL mid_no_done: got %0d want 0", dc.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_area();
    test_clip();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
